// File: rtl/xosera_board_io.sv
// Board-level I/O wrapper: bus pad tristate, registered interrupt/video outputs and
// PLL-lock-qualified core reset. Optional warm-boot passthrough under XOSERA_WARMBOOT_EN.
module xosera_board_io #(
   parameter int unsigned RESET_HOLD = 1
) (
   input  logic       clk,
   input  logic       reset_n_i,
   input  logic       pll_lock_i,
   input  logic       bus_cs_n_i,
   input  logic       bus_rd_nwr_i,
   inout  wire  [7:0] bus_data_io,
   output logic [7:0] bus_data_o,
   input  logic [7:0] core_data_i,
   input  logic       core_intr_i,
   input  logic       core_reconfig_i,
   input  logic [1:0] core_boot_sel_i,
   output logic       intr_o,
   output logic       spi_cs_o,
   output logic       warmboot_o,
   output logic [1:0] boot_sel_o,
   input  logic       vid_de_i,
   input  logic       vid_hs_i,
   input  logic       vid_vs_i,
   input  logic [3:0] vid_r_i,
   input  logic [3:0] vid_g_i,
   input  logic [3:0] vid_b_i,
   output logic       dv_de_o,
   output logic       dv_hs_o,
   output logic       dv_vs_o,
   output logic [3:0] dv_r_o,
   output logic [3:0] dv_g_o,
   output logic [3:0] dv_b_o,
   output logic       dv_clk_o,
   output logic       core_reset_o
);

   typedef enum logic {HOLD, RUN} rst_state_t;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } vid_t;

   rst_state_t state, state_nxt;
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic [7:0] rd_data_q;
   logic       intr_q;
   vid_t       vid_q;
   logic       oe;

   assign spi_cs_o = 1'b1;

   // No bus-side state: oe follows the strobes directly so a mid-read change acts at once
   assign oe          = !bus_cs_n_i && bus_rd_nwr_i;
   assign bus_data_io = oe ? rd_data_q : 8'hzz;
   assign bus_data_o  = bus_data_io;

   // Output DDR 0/1 pattern: rising edge lands mid-way between data changes
   assign dv_clk_o = ~clk;

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      case (state)
         HOLD: begin
            if (!pll_lock_i) begin
               hold_cnt_nxt = 8'd0;
            end else if (hold_cnt == 8'(RESET_HOLD - 1)) begin
               state_nxt    = RUN;
               hold_cnt_nxt = 8'd0;
            end else begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
         end
         RUN: begin
            if (!pll_lock_i) begin
               state_nxt    = HOLD;
               hold_cnt_nxt = 8'd0;
            end
         end
         default: begin
            state_nxt    = HOLD;
            hold_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= HOLD;
         hold_cnt  <= 8'd0;
         rd_data_q <= 8'd0;
         intr_q    <= 1'b0;
         vid_q     <= '0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_cnt_nxt;
         rd_data_q <= core_data_i;
         intr_q    <= core_intr_i;
         vid_q     <= '{de: vid_de_i, hs: vid_hs_i, vs: vid_vs_i,
                        r: vid_r_i, g: vid_g_i, b: vid_b_i};
      end
   end

   assign core_reset_o = (state == HOLD);
   assign intr_o       = intr_q;
   assign dv_de_o      = vid_q.de;
   assign dv_hs_o      = vid_q.hs;
   assign dv_vs_o      = vid_q.vs;
   assign dv_r_o       = vid_q.r;
   assign dv_g_o       = vid_q.g;
   assign dv_b_o       = vid_q.b;

`ifdef XOSERA_WARMBOOT_EN
   logic       warmboot_q;
   logic [1:0] boot_sel_q;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         warmboot_q <= 1'b0;
         boot_sel_q <= 2'd0;
      end else begin
         warmboot_q <= core_reconfig_i;
         boot_sel_q <= core_boot_sel_i;
      end
   end

   assign warmboot_o = warmboot_q;
   assign boot_sel_o = boot_sel_q;
`else
   logic unused_reconfig;
   assign unused_reconfig = ^{core_reconfig_i, core_boot_sel_i};
   assign warmboot_o      = 1'b0;
   assign boot_sel_o      = 2'd0;
`endif

endmodule

// File: tb/tb_xosera_board_io.sv
// Randomized + directed bench for xosera_board_io, checked against a cycle-level model
// built from lock run-lengths and previous-cycle input snapshots.
module tb_xosera_board_io;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       lock = 1'b1;
   logic       cs_n = 1'b1, rd_nwr = 1'b0;
   logic [7:0] core_data = '0;
   logic       intr = 1'b0, reconfig = 1'b0;
   logic [1:0] boot = '0;
   logic       de = 0, hs = 0, vs = 0;
   logic [3:0] vr = '0, vg = '0, vb = '0;
   logic       tb_pad_en = 1'b0;
   logic [7:0] tb_pad_val = '0;

   wire  [7:0] pad;
   wire  [7:0] pad4;
   logic [7:0] bus_out, bus_out4;
   logic       intr_o, spi_cs, wb, dv_de, dv_hs, dv_vs, dv_clk, core_rst;
   logic [1:0] bs;
   logic [3:0] dv_r, dv_g, dv_b;
   logic       intr4, spi4, wb4, de4, hs4, vs4, dvclk4, core_rst4;
   logic [1:0] bs4;
   logic [3:0] r4, g4, b4;

   assign pad = tb_pad_en ? tb_pad_val : 8'hzz;

   always #5 clk = ~clk;

   xosera_board_io #(.RESET_HOLD(1)) dut (
      .clk(clk), .reset_n_i(reset_n), .pll_lock_i(lock),
      .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rd_nwr), .bus_data_io(pad), .bus_data_o(bus_out),
      .core_data_i(core_data), .core_intr_i(intr), .core_reconfig_i(reconfig),
      .core_boot_sel_i(boot), .intr_o(intr_o), .spi_cs_o(spi_cs), .warmboot_o(wb),
      .boot_sel_o(bs), .vid_de_i(de), .vid_hs_i(hs), .vid_vs_i(vs),
      .vid_r_i(vr), .vid_g_i(vg), .vid_b_i(vb), .dv_de_o(dv_de), .dv_hs_o(dv_hs),
      .dv_vs_o(dv_vs), .dv_r_o(dv_r), .dv_g_o(dv_g), .dv_b_o(dv_b), .dv_clk_o(dv_clk),
      .core_reset_o(core_rst));

   xosera_board_io #(.RESET_HOLD(4)) dut4 (
      .clk(clk), .reset_n_i(reset_n), .pll_lock_i(lock),
      .bus_cs_n_i(1'b1), .bus_rd_nwr_i(1'b0), .bus_data_io(pad4), .bus_data_o(bus_out4),
      .core_data_i(core_data), .core_intr_i(intr), .core_reconfig_i(reconfig),
      .core_boot_sel_i(boot), .intr_o(intr4), .spi_cs_o(spi4), .warmboot_o(wb4),
      .boot_sel_o(bs4), .vid_de_i(de), .vid_hs_i(hs), .vid_vs_i(vs),
      .vid_r_i(vr), .vid_g_i(vg), .vid_b_i(vb), .dv_de_o(de4), .dv_hs_o(hs4),
      .dv_vs_o(vs4), .dv_r_o(r4), .dv_g_o(g4), .dv_b_o(b4), .dv_clk_o(dvclk4),
      .core_reset_o(core_rst4));

   int errors = 0;
   int checks = 0;

   // Model: previous-cycle snapshots plus the length of the current run of locked samples
   logic [7:0]  m_data;
   logic        m_intr, m_wb;
   logic [1:0]  m_bs;
   logic [14:0] m_vid;
   int          run_len;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_data = '0; m_intr = 0; m_wb = 0; m_bs = '0; m_vid = '0; run_len = 0;
   endtask

   task automatic check_regs();
      chk("core_reset_h1", {7'd0, core_rst}, {7'd0, run_len < 1});
      chk("core_reset_h4", {7'd0, core_rst4}, {7'd0, run_len < 4});
      chk("dv_ctl", {5'd0, dv_de, dv_hs, dv_vs}, {5'd0, m_vid[14:12]});
      chk("dv_rgb_rg", {dv_r, dv_g}, m_vid[11:4]);
      chk("dv_b", {4'd0, dv_b}, {4'd0, m_vid[3:0]});
      chk("intr_o", {7'd0, intr_o}, {7'd0, m_intr});
      chk("spi_cs", {7'd0, spi_cs}, 8'd1);
`ifdef XOSERA_WARMBOOT_EN
      chk("warmboot", {5'd0, wb, bs}, {5'd0, m_wb, m_bs});
`else
      chk("warmboot", {5'd0, wb, bs}, 8'd0);
`endif
      chk("dv_clk_lo", {7'd0, dv_clk}, 8'd1);
   endtask

   // Caller has driven inputs just after a negedge; run one full clock and check.
   task automatic tick();
      logic oe;
      oe = !cs_n && rd_nwr;
      tb_pad_en = !oe;
      #1;
      chk("bus_data_o", bus_out, oe ? m_data : tb_pad_val);
      @(posedge clk);
      if (!reset_n) model_reset();
      else begin
         m_data  = core_data;
         m_intr  = intr;
         m_wb    = reconfig;
         m_bs    = boot;
         m_vid   = {de, hs, vs, vr, vg, vb};
         run_len = lock ? run_len + 1 : 0;
      end
      #1;
      chk("dv_clk_hi", {7'd0, dv_clk}, 8'd0);
      @(negedge clk);
      check_regs();
   endtask

   task automatic rand_inputs();
      cs_n = 1'($urandom_range(0, 1));
      rd_nwr = 1'($urandom_range(0, 1));
      core_data = 8'($urandom);
      tb_pad_val = 8'($urandom);
      intr = 1'($urandom_range(0, 1));
      reconfig = 1'($urandom_range(0, 1));
      boot = 2'($urandom);
      {de, hs, vs, vr, vg, vb} = 15'($urandom);
   endtask

   initial begin
      model_reset();
      // Reset held with lock high: core stays in reset, outputs zero
      @(negedge clk);
      rand_inputs();
      tick();
      tick();
      chk("rst_core_reset", {7'd0, core_rst}, 8'd1);
      chk("rst_dv_r", {4'd0, dv_r}, 8'd0);

      // Release; RESET_HOLD=1 leaves reset after one clock
      reset_n = 1'b1;
      lock = 1'b1;
      tick();
      chk("rel_h1", {7'd0, core_rst}, 8'd0);
      chk("rel_h4_still", {7'd0, core_rst4}, 8'd1);

      // RESET_HOLD=4: lock drops at cycle 2, then must stay high 4 clocks
      lock = 1'b0; tick();
      lock = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("h4_3rd", {7'd0, core_rst4}, 8'd1);
      tick();
      chk("h4_release", {7'd0, core_rst4}, 8'd0);
      lock = 1'b0; tick();
      chk("h4_drop", {7'd0, core_rst4}, 8'd1);
      chk("h1_drop", {7'd0, core_rst}, 8'd1);
      lock = 1'b1; tick();

      // Bus read then write turnaround
      cs_n = 0; rd_nwr = 1; core_data = 8'hA5; tick();
      chk("pad_rd", bus_out, 8'hA5);
      rd_nwr = 0; tb_pad_en = 1; tb_pad_val = 8'h3C; #1;
      chk("pad_wr_now", bus_out, 8'h3C);
      tick();

      // Video registered exactly once
      vr = 4'hF; hs = 1; tick();
      chk("dv_r_F", {4'd0, dv_r}, 8'h0F);
      chk("dv_hs_1", {7'd0, dv_hs}, 8'd1);
      vr = 4'h0; hs = 0; #1;
      chk("dv_r_hold", {4'd0, dv_r}, 8'h0F);
      tick();

      // Interrupt pulse and warm-boot request
      intr = 1; reconfig = 1; boot = 2'd2; tick();
      chk("intr_pulse", {7'd0, intr_o}, 8'd1);
      intr = 0; reconfig = 0; boot = 2'd0; tick();
      chk("intr_clear", {7'd0, intr_o}, 8'd0);

      // Randomized traffic, lock biased high
      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         lock = ($urandom_range(0, 9) != 0);
         tick();
      end

      // Asynchronous reset mid-cycle
      reset_n = 1'b0; #1;
      chk("async_core_reset", {7'd0, core_rst}, 8'd1);
      chk("async_dv", {dv_r, dv_g}, 8'd0);
      chk("async_intr", {7'd0, intr_o}, 8'd0);
      model_reset();
      rand_inputs();
      tick();
      reset_n = 1'b1; lock = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rand_inputs();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xosera_board_io.md
XOSERA_BOARD_IO -- requirements
Module: xosera_board_io

Interface
REQ-001 Parameter RESET_HOLD, default 1, consecutive locked cycles before core reset release (legal 1..255).
REQ-002 clk  in  1  pixel clock (PLL output); sole clock.
REQ-003 reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 pll_lock_i  in  1  PLL lock indicator (asynchronous to nothing; sampled on clk).
REQ-005 bus_cs_n_i, bus_rd_nwr_i  in  1 each  bus select (low active), read-not-write (high = read).
REQ-006 bus_data_io  inout  8  bidirectional bus pad.
REQ-007 bus_data_o  out  8  pad data to core; core_data_i  in  8  read data from core.
REQ-008 core_intr_i, core_reconfig_i  in  1 each; core_boot_sel_i  in  2.
REQ-009 intr_o  out  1  registered interrupt pin; spi_cs_o  out  1  flash select.
REQ-010 warmboot_o  out  1, boot_sel_o  out  2  warm-boot request and image select.
REQ-011 vid_de_i, vid_hs_i, vid_vs_i  in  1 each; vid_r_i, vid_g_i, vid_b_i  in  4 each.
REQ-012 dv_de_o, dv_hs_o, dv_vs_o  out  1 each; dv_r_o, dv_g_o, dv_b_o  out  4 each; dv_clk_o  out  1.
REQ-013 core_reset_o  out  1  active-high reset to core.

Function
REQ-014 spi_cs_o SHALL be constant 1.
REQ-015 Output enable SHALL be combinational: oe = (bus_cs_n_i==0 && bus_rd_nwr_i==1); bus_data_io driven when oe, else high-Z.
REQ-016 Driven pad value SHALL be core_data_i registered one clk (1-cycle latency); bus_data_o SHALL be pad value, combinational, regardless of oe.
REQ-017 intr_o, warmboot_o, boot_sel_o SHALL be core_intr_i, core_reconfig_i, core_boot_sel_i delayed exactly one clk.
REQ-018 All 15 video signals SHALL be registered once; dv_* equals vid_* of previous clk, bit order preserved.
REQ-019 dv_clk_o SHALL be 0 during clk high phase and 1 during clk low phase (DDR 0/1, i.e. ~clk), so its rising edge precedes next data change by half a period.
REQ-020 Reset FSM states: HOLD (core_reset_o=1), RUN (core_reset_o=0).
REQ-021 HOLD->RUN when pll_lock_i sampled high for RESET_HOLD consecutive clks; counter clears whenever pll_lock_i low.
REQ-022 RUN->HOLD on first clk pll_lock_i sampled low (1-cycle latency); counter restarts.
REQ-023 With RESET_HOLD=1, core_reset_o SHALL equal ~pll_lock_i delayed one clk.
REQ-024 oe change mid-read SHALL take effect immediately; no bus-side state held.

Reset
REQ-025 reset_n_i low SHALL asynchronously: core_reset_o=1, FSM=HOLD, counter=0, all other registers 0 (dv_* 0, intr_o 0, warmboot_o 0, boot_sel_o 0, registered bus data 0).
REQ-026 dv_clk_o and oe are unaffected by reset_n_i; release is synchronous-deasserting on next clk edge.

Configuration
REQ-027 Macro XOSERA_WARMBOOT_EN defined: warmboot_o/boot_sel_o behave per REQ-017.
REQ-028 Macro undefined: warmboot_o=0, boot_sel_o=0 constant; core_reconfig_i, core_boot_sel_i ignored, no registers inferred for them.

Verification
REQ-029 reset_n_i=0, pll_lock_i=1 -> core_reset_o=1, dv_* 0; release, RESET_HOLD=1 -> core_reset_o=0 after 1 clk.
REQ-030 RESET_HOLD=4, pll_lock_i high, low at cycle 2, high again -> release exactly 4 clks after final rise; lock drop in RUN -> core_reset_o=1 next clk.
REQ-031 cs_n=0, rd_nwr=1, core_data_i=0xA5 -> pad 0xA5 one clk later; rd_nwr=0 -> pad Z same cycle, bus_data_o follows external 0x3C.
REQ-032 vid_r_i=0xF, vid_hs_i=1 at edge N -> dv_r_o=0xF, dv_hs_o=1 after edge N only; dv_clk_o=~clk throughout.
REQ-033 XOSERA_WARMBOOT_EN defined, core_reconfig_i=1, boot_sel=2 -> warmboot_o=1, boot_sel_o=2 next clk; undefined -> both stay 0.
REQ-034 core_intr_i pulse 1 clk -> intr_o 1-clk pulse delayed 1 clk; spi_cs_o=1 always.
